// File: rtl/dram_arb_pkg.sv
// Purpose : shared types and helpers for the two-port data-RAM arbiter.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents: FSM state encoding, owner IDs, full-word byte-enable constant,
//           byte_merge() used for read-modify-write sub-word stores.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic       OWNER_CPU = 1'b0;
  localparam logic       OWNER_DBG = 1'b1;
  localparam logic [3:0] BE_FULL   = 4'hF;

  // Byte i of the result comes from new_w when be[i] is set, else from old_w.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    if (be == BE_FULL) begin
      res = new_w;
    end else begin
      for (int i = 0; i < 4; i++) begin
        res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dram_arb_pick.sv
// Purpose : two-way request picker for the data-RAM arbiter.
// Latency : purely combinational, same-cycle grant.
// Backpr. : none; caller qualifies grants with its own ready/state.
//
// Ports   : req0/req1 requests in, grant0/grant1 one-hot (or zero) grants out,
//           last = port granted most recently (only with DRAM_ARB_ROUND_ROBIN_EN).
// Config  : DRAM_ARB_ROUND_ROBIN_EN defined -> round robin on conflict,
//           otherwise fixed priority with port 0 winning.
module dram_arb_pick (
`ifdef DRAM_ARB_ROUND_ROBIN_EN
  input  logic last,
`endif
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  always_comb begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    // On conflict favour the port that was not granted last.
    grant0 = req0 & (~req1 | last);
    grant1 = req1 & (~req0 | ~last);
`else
    grant0 = req0;
    grant1 = req1 & ~req0;
`endif
  end

endmodule

// File: rtl/dram_arbiter.sv
// Purpose : shares one async-read/sync-write word RAM between CPU (port 0) and debug loader (port 1).
// Latency : gnt at T, RAM write at edge ending T+1, rvalid at T+2; one txn per 3 cycles peak.
// Backpr. : requester holds req and payload until gnt; only one transaction outstanding in total.
//
// Ports   : clk, rst (sync, active high); m0_*/m1_* request (req/we/addr/be/wdata) and
//           response (gnt/rvalid/rdata) sets; dram_a/dram_we/dram_d to the RAM, dram_spo back.
// Config  : DRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [3:0]           m0_be,
  input  logic [31:0]          m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [31:0]          m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [3:0]           m1_be,
  input  logic [31:0]          m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [31:0]          m1_rdata,
  output logic [ADDR_BITS-1:0] dram_a,
  output logic                 dram_we,
  output logic [31:0]          dram_d,
  input  logic [31:0]          dram_spo
);

  state_t                 state_q, state_d;
  logic                   owner_q, we_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [3:0]             be_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata0_q, rdata1_q;
  logic                   pick0, pick1;
  logic                   any_gnt;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Reset to port 1 so port 0 wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst)          last_q <= OWNER_DBG;
    else if (any_gnt) last_q <= m1_gnt;
  end
`endif

  dram_arb_pick u_pick (
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    .last   (last_q),
`endif
    .req0   (m0_req),
    .req1   (m1_req),
    .grant0 (pick0),
    .grant1 (pick1)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = ST_IDLE;
    unique case (state_q)
      ST_IDLE:   state_d = any_gnt ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    m0_gnt    = (state_q == ST_IDLE) & pick0 & ~rst;
    m1_gnt    = (state_q == ST_IDLE) & pick1 & ~rst;
    any_gnt   = m0_gnt | m1_gnt;
    m0_rvalid = (state_q == ST_RESP) & (owner_q == OWNER_CPU) & ~rst;
    m1_rvalid = (state_q == ST_RESP) & (owner_q == OWNER_DBG) & ~rst;
    dram_a    = addr_q;
    dram_we   = 1'b0;
    dram_d    = '0;
    if (state_q == ST_ACCESS) begin
      // Sub-word store: read old word and rewrite it merged in the same cycle.
      dram_d  = byte_merge(dram_spo, wdata_q, be_q);
      dram_we = we_q & (be_q != 4'h0) & ~rst;
    end
  end

  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

  // Request latch and per-port load data
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWNER_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (any_gnt) begin
        owner_q <= m1_gnt ? OWNER_DBG : OWNER_CPU;
        we_q    <= m1_gnt ? m1_we    : m0_we;
        addr_q  <= m1_gnt ? m1_addr  : m0_addr;
        be_q    <= m1_gnt ? m1_be    : m0_be;
        wdata_q <= m1_gnt ? m1_wdata : m0_wdata;
      end
      if (state_q == ST_ACCESS && !we_q) begin
        if (owner_q == OWNER_DBG) rdata1_q <= dram_spo;
        else                      rdata0_q <= dram_spo;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Purpose : self-checking bench for dram_arbiter with a small behavioural RAM.
// Latency : checks gnt at T, rvalid at T+2, RAM contents after completion.
// Backpr. : requests are held until granted, then dropped.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [15:0] dram_a;
  logic        dram_we;
  logic [31:0] dram_d, dram_spo;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural RAM: async read, sync write, plus a bench preload port.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_dat = '0;
  int          wr_cnt = 0;

  assign dram_spo = mem[dram_a[7:0]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (dram_we) begin
      mem[dram_a[7:0]] <= dram_d;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always #5 clk = ~clk;

  dram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .dram_a(dram_a), .dram_we(dram_we), .dram_d(dram_d), .dram_spo(dram_spo)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ram_init;
    logic [31:0] exp_rdata;
    logic [31:0] exp_ram;
    int          exp_wr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic p, input logic req, input logic we, input logic [15:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    if (p) begin m1_req = req; m1_we = we; m1_addr = a; m1_be = be; m1_wdata = wd; end
    else   begin m0_req = req; m0_we = we; m0_addr = a; m0_be = be; m0_wdata = wd; end
  endtask

  function automatic logic gnt_of(input logic p);
    return p ? m1_gnt : m0_gnt;
  endfunction
  function automatic logic rv_of(input logic p);
    return p ? m1_rvalid : m0_rvalid;
  endfunction
  function automatic logic [31:0] rd_of(input logic p);
    return p ? m1_rdata : m0_rdata;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   w0;
    v = vecs[i];
    preload(v.addr[7:0], v.ram_init);
    w0 = wr_cnt;
    drive(v.port, 1'b1, v.we, v.addr, v.be, v.wdata);
    #1;
    chk($sformatf("v%0d gnt_T", i), {31'd0, gnt_of(v.port)}, 32'd1);
    chk($sformatf("v%0d other_gnt_T", i), {31'd0, gnt_of(~v.port)}, 32'd0);
    tick();
    drive(v.port, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    #1;
    chk($sformatf("v%0d gnt_rv_T1", i), {30'd0, gnt_of(v.port), rv_of(v.port)}, 32'd0);
    tick();
    #1;
    chk($sformatf("v%0d rvalid_T2", i), {30'd0, rv_of(~v.port), rv_of(v.port)}, 32'd1);
    chk($sformatf("v%0d rdata", i), rd_of(v.port), v.exp_rdata);
    tick();
    chk($sformatf("v%0d ram", i), mem[v.addr[7:0]], v.exp_ram);
    chk($sformatf("v%0d writes", i), wr_cnt - w0, v.exp_wr);
  endtask

  initial begin
    logic        gq [$];
    logic        exp_seq [4];
    int          dbl;
    logic [31:0] idle_or;

    //           port we  addr     be     wdata         ram_init      exp_rdata     exp_ram       wr
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 4'h0, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0};
    vecs[1] = '{1'b1, 1'b1, 16'h0004, 4'h2, 32'h0000AB00, 32'h11223344, 32'h00000000, 32'h1122AB44, 1};
    vecs[2] = '{1'b0, 1'b1, 16'h0030, 4'hF, 32'hCAFEF00D, 32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D, 1};
    vecs[3] = '{1'b1, 1'b0, 16'h0004, 4'h0, 32'h00000000, 32'h1122AB44, 32'h1122AB44, 32'h1122AB44, 0};
    vecs[4] = '{1'b0, 1'b1, 16'h0040, 4'h9, 32'hAA0000BB, 32'h11223344, 32'hDEADBEEF, 32'hAA2233BB, 1};
    vecs[5] = '{1'b0, 1'b1, 16'h0020, 4'h0, 32'hFFFFFFFF, 32'h00000055, 32'hDEADBEEF, 32'h00000055, 0};
    vecs[6] = '{1'b1, 1'b0, 16'h0050, 4'h0, 32'h00000000, 32'h01020304, 32'h01020304, 32'h01020304, 0};

    drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    rst = 1'b1;
    tick();
    chk("reset_outputs", {27'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dram_we}, 32'd0);
    chk("reset_dram_a", {16'd0, dram_a}, 32'd0);
    tick();
    rst = 1'b0;

    // Idle bus for 10 cycles: nothing may toggle.
    idle_or = '0;
    for (int c = 0; c < 10; c++) begin
      idle_or |= {27'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dram_we};
      idle_or |= m0_rdata | m1_rdata;
      tick();
    end
    chk("idle_10_cycles", idle_or, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Both ports requesting loads continuously.
    preload(8'h10, 32'hA0A0A0A0);
    preload(8'h04, 32'hB1B1B1B1);
    do_reset();
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    dbl = 0;
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 4'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0004, 4'h0, 32'h0);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m0_gnt && m1_gnt) dbl++;
      else if (m0_gnt) gq.push_back(1'b0);
      else if (m1_gnt) gq.push_back(1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("conflict_double_gnt", dbl, 0);
    chk("conflict_gnt_count", gq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gq.size()) chk($sformatf("conflict_gnt%0d", k), {31'd0, gq[k]}, {31'd0, exp_seq[k]});
      else               chk($sformatf("conflict_gnt%0d_missing", k), 32'd1, 32'd0);
    end
    chk("conflict_m0_rdata", m0_rdata, 32'hA0A0A0A0);
    tick();
    tick();

    // Reset during ACCESS of a full-word store.
    preload(8'h08, 32'h12345678);
    begin
      int w0;
      int rv;
      w0 = wr_cnt;
      rv = 0;
      drive(1'b0, 1'b1, 1'b1, 16'h0008, 4'hF, 32'hFFFFFFFF);
      #1;
      chk("rstacc_gnt", {31'd0, m0_gnt}, 32'd1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
      rst = 1'b1;
      #1;
      chk("rstacc_dram_we", {31'd0, dram_we}, 32'd0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
        #1;
        if (m0_rvalid || m1_rvalid) rv++;
        tick();
      end
      chk("rstacc_no_rvalid", rv, 0);
      chk("rstacc_ram", mem[8], 32'h12345678);
      chk("rstacc_writes", wr_cnt - w0, 0);
    end
    // Back in IDLE: a fresh request is granted at once and completes.
    drive(1'b1, 1'b1, 1'b0, 16'h0008, 4'h0, 32'h0);
    #1;
    chk("post_rst_gnt", {31'd0, m1_gnt}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    tick();
    #1;
    chk("post_rst_rvalid", {31'd0, m1_rvalid}, 32'd1);
    chk("post_rst_rdata", m1_rdata, 32'h12345678);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
